// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between i-side and d-side; grant is 1 cycle after request.
// Backpressure: requests are level-held and wait through BUSY/RELEASE; a stuck BUSY raises timeout_err.
module mem_arbiter #(
    parameter int TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_read,
    input  logic [15:0] i_address,
    output logic        i_resp,
    output logic [15:0] i_rdata,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [1:0]  d_byte_enable,
    input  logic [15:0] d_address,
    input  logic [15:0] d_wdata,
    output logic        d_resp,
    output logic [15:0] d_rdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [1:0]  mem_byte_enable,
    output logic [15:0] mem_address,
    output logic [15:0] mem_wdata,
    input  logic        mem_resp,
    input  logic [15:0] mem_rdata,
    output logic        timeout_err
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RELEASE} state_t;

    state_t        state;
    logic          last_grant;
    logic [CW-1:0] wd_cnt;
    logic          i_req;
    logic          d_req;
    logic          busy;

    assign i_req = i_read;
    assign d_req = d_read | d_write;
    assign busy  = (state == BUSY_I) || (state == BUSY_D);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // On a tie the side that did not win last time gets the port.
                    if (i_req && (!d_req || last_grant))
                        state <= BUSY_I;
                    else if (d_req)
                        state <= BUSY_D;
                end
                BUSY_I: begin
                    if (mem_resp) begin
                        last_grant <= 1'b0;
                        state      <= RELEASE;
                    end
                end
                BUSY_D: begin
                    if (mem_resp) begin
                        last_grant <= 1'b1;
                        state      <= RELEASE;
                    end
                end
                RELEASE: state <= IDLE;
                default: state <= IDLE;
            endcase

            // Flag is set on the edge that completes the TIMEOUT-th busy cycle.
            if (busy) begin
                if (wd_cnt != TMAX)
                    wd_cnt <= wd_cnt + CW'(1);
                if (wd_cnt >= TMAX - CW'(1))
                    timeout_err <= 1'b1;
            end else begin
                wd_cnt <= '0;
            end
        end
    end

    always_comb begin
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_byte_enable = 2'b00;
        mem_address     = 16'h0000;
        mem_wdata       = 16'h0000;
        i_resp          = 1'b0;
        d_resp          = 1'b0;
        case (state)
            BUSY_I: begin
                mem_read        = 1'b1;
                mem_byte_enable = 2'b11;
                mem_address     = i_address;
                i_resp          = mem_resp;
            end
            BUSY_D: begin
                mem_read        = d_read;
                mem_write       = d_write;
                mem_byte_enable = d_byte_enable;
                mem_address     = d_address;
                mem_wdata       = d_wdata;
                d_resp          = mem_resp;
            end
            default: ;
        endcase
    end

    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_read;
    logic [15:0] i_address;
    logic        i_resp;
    logic [15:0] i_rdata;
    logic        d_read;
    logic        d_write;
    logic [1:0]  d_byte_enable;
    logic [15:0] d_address;
    logic [15:0] d_wdata;
    logic        d_resp;
    logic [15:0] d_rdata;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_byte_enable;
    logic [15:0] mem_address;
    logic [15:0] mem_wdata;
    bit          mem_resp;
    logic [15:0] mem_rdata;
    logic        timeout_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT(8)) dut (
        .clk(clk), .reset(reset),
        .i_read(i_read), .i_address(i_address), .i_resp(i_resp), .i_rdata(i_rdata),
        .d_read(d_read), .d_write(d_write), .d_byte_enable(d_byte_enable),
        .d_address(d_address), .d_wdata(d_wdata), .d_resp(d_resp), .d_rdata(d_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
        .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_resp(mem_resp),
        .mem_rdata(mem_rdata), .timeout_err(timeout_err)
    );

    // Memory model: responds on the third cycle of a held request; stall suppresses resp.
    logic [15:0] mem [0:127];
    bit          loaded = 1'b0;
    bit          stall  = 1'b0;
    int          lat_cnt = 0;

    always @(posedge clk) begin
        mem_resp <= 1'b0;
        if (!loaded) begin
            mem[8]  <= 16'hBEEF;
            mem[16] <= 16'hCDEF;
            loaded  <= 1'b1;
        end else if (!stall && (mem_read || mem_write) && !mem_resp) begin
            if (lat_cnt == 1) begin
                lat_cnt  <= 0;
                mem_resp <= 1'b1;
                if (mem_write) begin
                    if (mem_byte_enable[0]) mem[mem_address[7:1]][7:0]  <= mem_wdata[7:0];
                    if (mem_byte_enable[1]) mem[mem_address[7:1]][15:8] <= mem_wdata[15:8];
                end
                mem_rdata <= mem[mem_address[7:1]];
            end else begin
                lat_cnt <= lat_cnt + 1;
            end
        end else begin
            lat_cnt <= 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_resp(output int n, output logic gi, output logic gd);
        n  = 0;
        gi = 1'b0;
        gd = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            n++;
            if (i_resp || d_resp) begin
                gi = i_resp;
                gd = d_resp;
                break;
            end
        end
    endtask

    int   n;
    logic gi, gd;

    initial begin
        reset = 1'b1;
        i_read = 1'b0; i_address = 16'h0;
        d_read = 1'b0; d_write = 1'b0; d_byte_enable = 2'b00;
        d_address = 16'h0; d_wdata = 16'h0;
        repeat (2) @(negedge clk);
        chk("rst_mem_read", mem_read, 1'b0);
        chk("rst_mem_write", mem_write, 1'b0);
        chk("rst_mem_be", mem_byte_enable, 2'b00);
        chk("rst_mem_addr", mem_address, 16'h0);
        chk("rst_i_resp", i_resp, 1'b0);
        chk("rst_d_resp", d_resp, 1'b0);
        chk("rst_timeout", timeout_err, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_mem_read", mem_read, 1'b0);

        // Single i-side read
        i_read = 1'b1; i_address = 16'h0010;
        @(negedge clk);
        chk("t1_mem_read", mem_read, 1'b1);
        chk("t1_mem_write", mem_write, 1'b0);
        chk("t1_mem_addr", mem_address, 16'h0010);
        chk("t1_mem_be", mem_byte_enable, 2'b11);
        wait_resp(n, gi, gd);
        chk("t1_i_resp", gi, 1'b1);
        chk("t1_d_resp", gd, 1'b0);
        chk("t1_latency", n, 2);
        chk("t1_rdata", i_rdata, 16'hBEEF);
        i_read = 1'b0;
        @(negedge clk);
        chk("t1_release_read", mem_read, 1'b0);
        chk("t1_resp_pulse", i_resp, 1'b0);
        @(negedge clk);

        // Single d-side byte write, then read back through i-side
        d_write = 1'b1; d_address = 16'h0020; d_wdata = 16'h1234; d_byte_enable = 2'b01;
        @(negedge clk);
        chk("t2_mem_write", mem_write, 1'b1);
        chk("t2_mem_read", mem_read, 1'b0);
        chk("t2_mem_be", mem_byte_enable, 2'b01);
        chk("t2_mem_wdata", mem_wdata, 16'h1234);
        chk("t2_mem_addr", mem_address, 16'h0020);
        wait_resp(n, gi, gd);
        chk("t2_d_resp", gd, 1'b1);
        chk("t2_i_resp", gi, 1'b0);
        d_write = 1'b0; d_byte_enable = 2'b00;
        repeat (2) @(negedge clk);
        i_read = 1'b1; i_address = 16'h0020;
        wait_resp(n, gi, gd);
        chk("t2_rb_resp", gi, 1'b1);
        chk("t2_rb_rdata", i_rdata, 16'hCD34);
        i_read = 1'b0;
        repeat (2) @(negedge clk);

        // Both sides held after reset: I, D, I, D
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        i_read = 1'b1; i_address = 16'h0010;
        d_read = 1'b1; d_address = 16'h0020;
        for (int t = 0; t < 4; t++) begin
            wait_resp(n, gi, gd);
            chk($sformatf("t3_grant%0d", t), {gd, gi}, (t % 2 == 0) ? 2'b01 : 2'b10);
            if (gi) chk($sformatf("t3_i_rdata%0d", t), i_rdata, 16'hBEEF);
            if (gd) chk($sformatf("t3_d_rdata%0d", t), d_rdata, 16'hCD34);
        end
        i_read = 1'b0; d_read = 1'b0;
        repeat (3) @(negedge clk);

        // Back-to-back d_read: next mem_read rise 3 cycles after d_resp
        d_read = 1'b1; d_address = 16'h0010;
        wait_resp(n, gi, gd);
        chk("t4_d_resp", gd, 1'b1);
        @(negedge clk);
        chk("t4_release_read", mem_read, 1'b0);
        @(negedge clk);
        chk("t4_idle_read", mem_read, 1'b0);
        @(negedge clk);
        chk("t4_regrant_read", mem_read, 1'b1);
        wait_resp(n, gi, gd);
        chk("t4_second_resp", gd, 1'b1);
        d_read = 1'b0;
        repeat (2) @(negedge clk);

        // Watchdog with memory never responding
        stall = 1'b1;
        i_read = 1'b1; i_address = 16'h0010;
        repeat (8) @(negedge clk);
        chk("t5_before_timeout", timeout_err, 1'b0);
        @(negedge clk);
        chk("t5_timeout_set", timeout_err, 1'b1);
        chk("t5_grant_held", mem_read, 1'b1);
        repeat (20) @(negedge clk);
        chk("t5_timeout_sticky", timeout_err, 1'b1);
        chk("t5_still_granted", mem_read, 1'b1);
        i_read = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("t5_reset_clears", timeout_err, 1'b0);
        chk("t5_reset_read", mem_read, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        // Async reset in the middle of a stalled BUSY_D
        d_write = 1'b1; d_address = 16'h0020; d_wdata = 16'hFFFF; d_byte_enable = 2'b11;
        repeat (10) @(negedge clk);
        chk("t6_busy_write", mem_write, 1'b1);
        chk("t6_timeout_set", timeout_err, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("t6_async_write", mem_write, 1'b0);
        chk("t6_async_read", mem_read, 1'b0);
        chk("t6_async_timeout", timeout_err, 1'b0);
        chk("t6_async_d_resp", d_resp, 1'b0);
        d_write = 1'b0; d_byte_enable = 2'b00;
        @(negedge clk);
        stall = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        chk("t6_idle_read", mem_read, 1'b0);

        // Arbiter usable after the aborted write; stalled write never reached memory
        i_read = 1'b1; i_address = 16'h0020;
        @(negedge clk);
        chk("t7_mem_read", mem_read, 1'b1);
        wait_resp(n, gi, gd);
        chk("t7_i_resp", gi, 1'b1);
        chk("t7_rdata", i_rdata, 16'hCD34);
        i_read = 1'b0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
